// File: rtl/softmax_seq_ctrl.sv
// softmax_seq_ctrl
// Sequences one softmax pass over N FP32 elements using shared arithmetic:
//   LOAD     accept N elements, track the running maximum
//   SUB/EXP  d = x - max, then buf = exp(d) (clamped to 0 when |d| >= 16)
//   ACC      sum += buf
//   DIV/OUT  q = buf / sum, streamed out one element at a time
//
// Handshakes:
//   in/out streams: a beat transfers on a rising clk edge where valid and
//   ready are both high. The producer holds valid and data stable until
//   that beat.
//   exp/div units: start is a level request. The operands stay stable while
//   start is high. The unit answers with a one-cycle done pulse. start drops
//   the cycle after done is sampled.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   start                one-cycle pass request (ignored unless idle)
//   in_valid/in_ready/in_data     input element stream
//   fadd_a/fadd_b/fadd_s          combinational FP32 adder (s = a + b)
//   exp_start/exp_in/exp_done/exp_result   iterative exp unit
//   div_start/div_a/div_b/div_done/div_q   divider (q = a / b)
//   out_valid/out_ready/out_data  probability stream
//   busy, done, err      status (err is sticky until the next start)
//   dbg_state            current FSM state, for observation
module softmax_seq_ctrl #(
    parameter int N   = 8,
    parameter int TMO = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic [31:0] fadd_a,
    output logic [31:0] fadd_b,
    input  logic [31:0] fadd_s,
    output logic        exp_start,
    output logic [31:0] exp_in,
    input  logic        exp_done,
    input  logic [31:0] exp_result,
    output logic        div_start,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_done,
    input  logic [31:0] div_q,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SUB, S_EXP_WAIT, S_ACC, S_DIV_WAIT, S_OUT, S_DONE
    } state_t;

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = IW + 1;
    localparam int WW = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [CW-1:0] LAST   = CW'(N - 1);
    localparam logic [WW-1:0] WD_LIM = WW'(TMO - 1);

    state_t        state, state_d;
    logic [31:0]   vbuf [N];
    logic [31:0]   max_q, sum_q, d_q, q_q;
    logic [CW-1:0] idx;
    logic [WW-1:0] wd;
    logic          err_q;

    logic [IW-1:0] cur_i;
    logic [31:0]   cur;
    logic          wd_exp;
    logic          clamp;

    // Sign-magnitude compare: no FP unit needed for the max search.
    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31])
            return !a[31];
        else if (!a[31])
            return a[30:0] > b[30:0];
        else
            return a[30:0] < b[30:0];
    endfunction

    assign cur_i     = idx[IW-1:0];
    assign cur       = vbuf[cur_i];
    assign wd_exp    = (wd == WD_LIM);
    // exponent >= 131 means |d| >= 16; exp() there is negligible or out of range
    assign clamp     = (fadd_s[30:23] >= 8'd131);
    assign err       = err_q;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        fadd_a    = 32'd0;
        fadd_b    = 32'd0;
        exp_start = 1'b0;
        exp_in    = 32'd0;
        div_start = 1'b0;
        div_a     = 32'd0;
        div_b     = 32'd0;
        out_valid = 1'b0;
        out_data  = 32'd0;
        done      = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && idx == LAST) state_d = S_SUB;
            end
            S_SUB: begin
                fadd_a  = cur;
                fadd_b  = {~max_q[31], max_q[30:0]};
                state_d = clamp ? S_ACC : S_EXP_WAIT;
            end
            S_EXP_WAIT: begin
                exp_start = 1'b1;
                exp_in    = d_q;
                if (exp_done || wd_exp) state_d = S_ACC;
            end
            S_ACC: begin
                fadd_a  = sum_q;
                fadd_b  = cur;
                state_d = (idx == LAST) ? S_DIV_WAIT : S_SUB;
            end
            S_DIV_WAIT: begin
                div_start = 1'b1;
                div_a     = cur;
                div_b     = sum_q;
                if (div_done || wd_exp) state_d = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                out_data  = q_q;
                if (out_ready) state_d = (idx == LAST) ? S_DONE : S_DIV_WAIT;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N; i++) vbuf[i] <= 32'd0;
            max_q <= 32'd0;
            sum_q <= 32'd0;
            d_q   <= 32'd0;
            q_q   <= 32'd0;
            idx   <= '0;
            wd    <= '0;
            err_q <= 1'b0;
        end else begin
            // watchdog runs only inside the two wait states, so it is zero on entry
            wd <= '0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        sum_q <= 32'd0;
                        err_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        vbuf[cur_i] <= in_data;
                        if (idx == '0 || fp_gt(in_data, max_q)) max_q <= in_data;
                        idx <= (idx == LAST) ? '0 : idx + 1'b1;
                    end
                end
                S_SUB: begin
                    d_q <= fadd_s;
                    if (clamp) vbuf[cur_i] <= 32'd0;
                end
                S_EXP_WAIT: begin
                    wd <= wd + 1'b1;
                    // a done arriving on the timeout cycle is still taken
                    if (exp_done) begin
                        vbuf[cur_i] <= exp_result;
                    end else if (wd_exp) begin
                        err_q       <= 1'b1;
                        vbuf[cur_i] <= 32'd0;
                    end
                end
                S_ACC: begin
                    sum_q <= fadd_s;
                    idx   <= (idx == LAST) ? '0 : idx + 1'b1;
                end
                S_DIV_WAIT: begin
                    wd <= wd + 1'b1;
                    if (div_done) begin
                        q_q <= div_q;
                    end else if (wd_exp) begin
                        err_q <= 1'b1;
                        q_q   <= 32'd0;
                    end
                end
                S_OUT: begin
                    if (out_ready) idx <= (idx == LAST) ? '0 : idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Testbench for softmax_seq_ctrl (N=4, TMO=16). Behavioural FP32 adder,
// exp unit and divider surround the controller; a reference softmax fills
// the expected queues before each pass starts.
module tb_softmax_seq_ctrl;

    localparam int N   = 4;
    localparam int TMO = 16;
    localparam logic [2:0] ST_SUB = 3'd2;

    logic        clk, rstn, start, in_valid, in_ready;
    logic [31:0] in_data, fadd_a, fadd_b, fadd_s;
    logic        exp_start, exp_done, div_start, div_done;
    logic [31:0] exp_in, exp_result, div_a, div_b, div_q;
    logic        out_valid, out_ready, busy, done, err;
    logic [31:0] out_data;
    logic [2:0]  dbg_state;

    softmax_seq_ctrl #(.N(N), .TMO(TMO)) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .fadd_a(fadd_a), .fadd_b(fadd_b), .fadd_s(fadd_s),
        .exp_start(exp_start), .exp_in(exp_in), .exp_done(exp_done), .exp_result(exp_result),
        .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_done(div_done), .div_q(div_q),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];      // expected out_data per beat
    logic [31:0] exp_in_q[$];   // expected exp operand per exp request
    logic [31:0] div_a_q[$];    // expected dividend per div request
    logic [31:0] vec [N];
    logic [31:0] exp_negmax, exp_sum;
    int exp_nexp, exp_err_v;
    int exp_silent = -1;
    int div_silent = -1;
    int stall_left = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    // ---------------- FP32 helpers (normal numbers, truncating) ----------------
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (d[62:0] == 63'd0 || e <= 0) return 32'd0;
        if (e >= 255) return {d[63], 8'hff, 23'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // ---------------- arithmetic unit models ----------------
    always_comb fadd_s = r2f(f2r(fadd_a) + f2r(fadd_b));

    int e_cnt = 0, e_lat = 2, e_req = 0;
    int d_cnt = 0, d_lat = 2, d_req = 0;

    always @(negedge clk) begin
        exp_done = 1'b0;
        if (!exp_start) e_cnt = 0;
        else begin
            if (e_cnt == 0) begin e_lat = $urandom_range(2, 5); e_req++; end
            e_cnt++;
            if (e_cnt == e_lat && (e_req - 1) != exp_silent) begin
                exp_done   = 1'b1;
                exp_result = r2f($exp(f2r(exp_in)));
            end
        end
        div_done = 1'b0;
        if (!div_start) d_cnt = 0;
        else begin
            if (d_cnt == 0) begin d_lat = $urandom_range(2, 5); d_req++; end
            d_cnt++;
            if (d_cnt == d_lat && (d_req - 1) != div_silent) begin
                div_done = 1'b1;
                div_q    = r2f(f2r(div_a) / f2r(div_b));
            end
        end
    end

    // ---------------- output ready driver ----------------
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // ---------------- monitor (samples on the falling edge) ----------------
    logic        prev_ov, prev_or, prev_es, prev_ds;
    logic [31:0] prev_od, got_w;
    int sub_ptr = 0, exp_req_cnt = 0, div_req_cnt = 0, done_cnt = 0;
    int es_run = 0, ds_run = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            prev_ov = 1'b0; prev_or = 1'b0; prev_es = 1'b0; prev_ds = 1'b0;
            prev_od = 32'd0; es_run = 0; ds_run = 0;
        end else begin
            if (prev_ov && !prev_or) begin
                check("out_hold_valid", {31'd0, out_valid}, 32'd1);
                check("out_hold_data", out_data, prev_od);
            end
            if (out_valid && out_ready) begin
                check("out_q_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    got_w = exp_q.pop_front();
                    check("out_data", out_data, got_w);
                end
            end
            if (dbg_state == ST_SUB) begin
                check("sub_fadd_b", fadd_b, exp_negmax);
                check("sub_fadd_a", fadd_a, (sub_ptr < N) ? vec[sub_ptr] : 32'hdeadbeef);
                sub_ptr++;
            end
            if (exp_start && !prev_es) begin
                exp_req_cnt++;
                check("exp_q_nonempty", {31'd0, exp_in_q.size() != 0}, 32'd1);
                if (exp_in_q.size() != 0) begin
                    got_w = exp_in_q.pop_front();
                    check("exp_in", exp_in, got_w);
                end
            end
            if (exp_start) es_run++;
            else if (prev_es) begin
                if (exp_req_cnt - 1 == exp_silent) check("exp_tmo_len", es_run, TMO);
                es_run = 0;
            end
            if (div_start && !prev_ds) begin
                div_req_cnt++;
                check("div_b_sum", div_b, exp_sum);
                if (div_a_q.size() != 0) begin
                    got_w = div_a_q.pop_front();
                    check("div_a", div_a, got_w);
                end
            end
            if (div_start) ds_run++;
            else if (prev_ds) begin
                if (div_req_cnt - 1 == div_silent) check("div_tmo_len", ds_run, TMO);
                ds_run = 0;
            end
            if (done) done_cnt++;
            prev_ov = out_valid; prev_or = out_ready; prev_od = out_data;
            prev_es = exp_start; prev_ds = div_start;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Reference softmax on vec[], then start the pass and stream vec[] in.
    task automatic launch_pass(input int se, input int sd, input int stall);
        logic [31:0] m, d, sum;
        logic [31:0] e [N];
        int t;
        logic acc;
        m = vec[0];
        for (int i = 1; i < N; i++) if (f2r(vec[i]) > f2r(m)) m = vec[i];
        exp_negmax = {~m[31], m[30:0]};
        sum = 32'd0;
        exp_nexp = 0;
        for (int i = 0; i < N; i++) begin
            d = r2f(f2r(vec[i]) + f2r(exp_negmax));
            if (d[30:23] >= 8'd131) e[i] = 32'd0;
            else begin
                exp_in_q.push_back(d);
                e[i] = (exp_nexp == se) ? 32'd0 : r2f($exp(f2r(d)));
                exp_nexp++;
            end
            sum = r2f(f2r(sum) + f2r(e[i]));
        end
        exp_sum = sum;
        for (int i = 0; i < N; i++) begin
            div_a_q.push_back(e[i]);
            exp_q.push_back((i == sd) ? 32'd0 : r2f(f2r(e[i]) / f2r(sum)));
        end
        exp_err_v  = ((se >= 0 && se < exp_nexp) || (sd >= 0 && sd < N)) ? 1 : 0;
        exp_silent = se; div_silent = sd; stall_left = stall;
        e_req = 0; d_req = 0;
        sub_ptr = 0; exp_req_cnt = 0; div_req_cnt = 0; done_cnt = 0;

        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            in_valid = 1'b1;
            in_data  = vec[i];
            t = 0; acc = 1'b0;
            while (!acc && t < 20) begin acc = in_ready; tick(); t++; end
            check("load_accept", {31'd0, acc}, 32'd1);
        end
        in_valid = 1'b0;
        in_data  = 32'd0;
    endtask

    task automatic finish_pass();
        int t;
        t = 0;
        while (done_cnt == 0 && t < 5000) begin tick(); t++; end
        check("done_seen", {31'd0, done_cnt != 0}, 32'd1);
        repeat (2) tick();
        check("done_once", done_cnt, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("err", {31'd0, err}, exp_err_v);
        check("exp_reqs", exp_req_cnt, exp_nexp);
        check("div_reqs", div_req_cnt, N);
        check("out_left", exp_q.size(), 32'd0);
    endtask

    task automatic poke_start();
        repeat (3) tick();
        start = 1'b1; tick(); start = 1'b0;
        check("poke_busy", {31'd0, busy}, 32'd1);
        check("poke_in_ready", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic fill_rand(input int span);
        for (int i = 0; i < N; i++)
            vec[i] = r2f(real'($urandom_range(0, 32 * span)) / 16.0 - real'(span));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t;
        rstn = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_exp_start", {31'd0, exp_start}, 32'd0);
        check("rst_div_start", {31'd0, div_start}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_fadd_b", fadd_b, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        rstn = 1'b1;
        tick();

        // uniform vector, output stall of 5 cycles, stray start mid-pass
        for (int i = 0; i < N; i++) vec[i] = 32'h3f800000;
        launch_pass(-1, -1, 5);
        poke_start();
        finish_pass();

        // max is the last element
        vec[0] = 32'd0; vec[1] = 32'd0; vec[2] = 32'd0; vec[3] = 32'h3f800000;
        launch_pass(-1, -1, 0);
        finish_pass();

        // elements 1..3 clamped (d = -20)
        vec[0] = 32'h41a00000; vec[1] = 32'd0; vec[2] = 32'd0; vec[3] = 32'd0;
        launch_pass(-1, -1, 0);
        finish_pass();

        // third exp request never answered
        for (int i = 0; i < N; i++) vec[i] = 32'h3f800000;
        launch_pass(2, -1, 0);
        finish_pass();

        // err cleared by start; divider silent on element 1
        fill_rand(5);
        launch_pass(-1, 1, 0);
        finish_pass();

        // wide spread, some elements clamp
        fill_rand(15);
        launch_pass(-1, -1, 2);
        finish_pass();

        // reset while waiting on exp
        fill_rand(5);
        launch_pass(-1, -1, 0);
        t = 0;
        while (!exp_start && t < 200) begin @(negedge clk); t++; end
        check("rst_mid_reached", {31'd0, exp_start}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("rst_mid_exp_start", {31'd0, exp_start}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        exp_q.delete(); exp_in_q.delete(); div_a_q.delete();
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        fill_rand(5);
        launch_pass(-1, -1, 0);
        finish_pass();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/softmax_seq_ctrl.md
# softmax_seq_ctrl

Sequencing controller for one softmax vector pass over the shared FP32 arithmetic units. It accepts N FP32 elements on a valid/ready stream and tracks their running maximum. It then drives the external adder, the iterative exp unit and the divider through their handshakes. It streams out N normalized probabilities and sits between the input buffer and the softmax output stage.

## Interface
- N, default 8: vector length, ≥2.
- TMO, default 64: exp/div watchdog limit in cycles.
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a pass (ignored unless IDLE)
- in_valid / in_data  in  1 / 32  input element stream
- in_ready  out  1  high only in LOAD
- fadd_a, fadd_b  out  32  operands to combinational FP32 adder (result = a+b)
- fadd_s  in  32  adder result, same cycle
- exp_start  out  1  level request to exp unit
- exp_in  out  32  exp operand
- exp_done / exp_result  in  1 / 32  exp completion pulse / value
- div_start  out  1  level request to divider
- div_a, div_b  out  32  dividend / divisor
- div_done / div_q  in  1 / 32  divider completion pulse / quotient
- out_valid / out_data  out  1 / 32  result stream
- out_ready  in  1
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse at end of pass
- err  out  1  sticky timeout flag, cleared by start

## Operation
- States: IDLE, LOAD, SUB, EXP_WAIT, ACC, DIV_WAIT, OUT, DONE.
- Storage: buf[0..N-1] (32b), max, sum, d, q (32b), idx ($clog2(N)+1 bits), wd counter.
- IDLE: on start, go to LOAD. Clear idx, sum=0, err=0.
- LOAD: each in_valid&in_ready writes buf[idx]=in_data. Element 0 sets max unconditionally. Later elements replace max only if strictly greater.
  - Greater-than rule: sign differs → positive wins. Both positive → larger [30:0] wins. Both negative → smaller [30:0] wins.
  - After element N-1, go to SUB with idx=0.
- SUB (1 cycle): fadd_a=buf[idx], fadd_b={~max[31],max[30:0]}, d<=fadd_s.
  - If fadd_s[30:23]≥131 (|d|≥16, out of exp range), write buf[idx]=0 and go to ACC.
  - Otherwise go to EXP_WAIT.
- EXP_WAIT: exp_start=1 and exp_in=d, both held stable until exp_done.
  - On exp_done: buf[idx]<=exp_result, go to ACC.
  - If wd reaches TMO: err<=1, buf[idx]<=0, go to ACC.
- ACC (1 cycle): fadd_a=sum, fadd_b=buf[idx], sum<=fadd_s, idx++.
  - If idx was N-1, go to DIV_WAIT with idx=0. Otherwise go to SUB.
- DIV_WAIT: div_start=1, div_a=buf[idx], div_b=sum, held until div_done.
  - On div_done: q<=div_q, go to OUT.
  - On timeout: err<=1, q<=0, go to OUT.
- OUT: out_valid=1, out_data=q.
  - On out_ready: idx++. Go to DIV_WAIT, or to DONE if idx was N-1.
- DONE: done=1 for one cycle, then go to IDLE.
- fadd_a/fadd_b are 0 outside SUB/ACC. exp_in, div_a and div_b are 0 when their request is low.
- start while busy has no effect. NaN/Inf inputs are not handled.

## Timing
- Reset values: state=IDLE; in_ready, exp_start, div_start, out_valid, busy, done and err are all 0; all data outputs are 0; all internal registers are 0.
- Reset mid-pass: immediate return to IDLE; requests drop asynchronously.
- exp_start rises the cycle after SUB. It falls the cycle after exp_done is sampled, i.e. at least 2 cycles high, as the exp unit requires.
- The same level rule applies to div_start.
- wd clears on entry to EXP_WAIT/DIV_WAIT and increments each cycle there. Timeout fires when wd==TMO-1 with no done.
- done coincident with timeout: done wins, err stays 0.
- Load latency: N accepted beats. Per element: 1 (SUB) + exp latency + 1 (ACC), or 2 cycles if clamped.
- out_data is stable while out_valid&!out_ready. The first output appears 1 cycle after the first div_done.

## Test plan
- N=4, all inputs 0x3f800000, ideal exp/div models:
  - max=0x3f800000; every exp_in=0x00000000 or 0x80000000; sum=0x40800000.
  - Four outputs 0x3e800000, then done pulses once.
- Inputs 0,0,0,0x3f800000: fadd_b=0xbf800000 in every SUB; the final max equals the last element.
- Inputs 0x41a00000,0,0,0:
  - Elements 1-3 give d=-20.0, are clamped and never assert exp_start.
  - Only element 0 requests exp; the output for element 0 is 1.0.
- Exp model never responds: after TMO cycles, err=1, the element contributes 0, and the pass still completes with done.
- Hold out_ready low 5 cycles during OUT: out_valid stays 1 and out_data unchanged. Pulse start during the pass: no effect.
- Deassert rstn during EXP_WAIT: exp_start, busy and out_valid go 0 at once. A new start after release runs a clean pass.
